// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing / test-pattern generator.
//   - 640x480@60 timing constants (used as the top-level defaults)
//   - pattern_sel encodings
//   - the eight colour-bar colours, in left-to-right order
package vtg_pkg;

  // 640x480@60 raster, 25.175 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_SOLID = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Bar index 0 is the leftmost bar.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vtg_pattern_rgb.sv
// Combinational test-pattern colour selection.
// Ports:
//   h_lsb     [7:0]  low bits of the horizontal counter (grid + ramp)
//   v_lsb     [4:0]  low bits of the vertical counter (grid)
//   bar_idx   [2:0]  current colour-bar index
//   pattern          latched pattern selection
//   solid_rgb [23:0] latched solid colour {R,G,B}
//   rgb       [23:0] selected colour {R,G,B}; blanking is applied by the caller
module vtg_pattern_rgb
  import vtg_pkg::*;
(
  input  logic [7:0]  h_lsb,
  input  logic [4:0]  v_lsb,
  input  logic [2:0]  bar_idx,
  input  pattern_e    pattern,
  input  logic [23:0] solid_rgb,
  output logic [23:0] rgb
);

  always_comb begin
    // NOTE: default first so every path assigns rgb and no latch is inferred.
    rgb = COL_BLACK;
    case (pattern)
      PAT_BARS:  rgb = bar_colour(bar_idx);
      PAT_SOLID: rgb = solid_rgb;
      PAT_GRID:  rgb = (h_lsb[4:0] == 5'd0 || v_lsb == 5'd0) ? COL_WHITE : COL_BLACK;
      PAT_RAMP:  rgb = {3{h_lsb}};
      default:   rgb = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Raster timing and test-pattern generator, pixel clock domain.
// All outputs are registered one cycle after the counter state they describe
// and are mutually aligned, ready to drive three TMDS channel encoders.
// Ports:
//   clkin              pixel clock
//   rstin              synchronous active-high reset
//   pattern_sel [1:0]  0 bars, 1 solid, 2 grid, 3 ramp (sampled at frame start)
//   solid_rgb   [23:0] solid colour {R,G,B} (sampled at frame start)
//   red/green/blue [7:0] pixel data, zero outside the active region
//   de                 data enable, high in the active region
//   hsync, vsync       syncs, active level HS_POL / VS_POL
//   frame_start        one-cycle pulse coincident with pixel (0,0)
module video_timing_pattern_gen
  import vtg_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 12
) (
  input  logic        clkin,
  input  logic        rstin,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int BAR_CW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic [BAR_CW-1:0] bar_px;
  logic [2:0]        bar_idx;
  pattern_e          pat_q;
  logic [23:0]       solid_q;

  logic        h_last;
  logic        v_last;
  logic        bar_last;
  logic        at_origin;
  logic        active;
  logic        hs_act;
  logic        vs_act;
  pattern_e    pat_eff;
  logic [23:0] solid_eff;
  logic [23:0] rgb_c;

  assign h_last    = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last    = (v_cnt == CNT_W'(V_TOTAL - 1));
  assign bar_last  = (bar_px == BAR_CW'(BAR_W - 1));
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs_act    = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
  // v_cnt only moves on the h wrap, so vsync naturally changes at h_cnt = 0.
  assign vs_act    = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));

  // Pixel (0,0) is the sampling point itself, so it already uses the fresh
  // selection; every later pixel of the frame uses the latched copy.
  assign pat_eff   = at_origin ? pattern_e'(pattern_sel) : pat_q;
  assign solid_eff = at_origin ? solid_rgb : solid_q;

  vtg_pattern_rgb u_pattern_rgb (
    .h_lsb     (h_cnt[7:0]),
    .v_lsb     (v_cnt[4:0]),
    .bar_idx   (bar_idx),
    .pattern   (pat_eff),
    .solid_rgb (solid_eff),
    .rgb       (rgb_c)
  );

  // NOTE: sequential state uses non-blocking assignments only, and rstin is
  // sampled on the clock edge (synchronous reset), never in the sensitivity list.
  always_ff @(posedge clkin) begin
    if (rstin) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      bar_px      <= '0;
      bar_idx     <= '0;
      pat_q       <= PAT_BARS;
      solid_q     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      // Raster counters, wrapping modulo their totals.
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end

      // Bar index without a divider: a bar-width sub-counter steps the
      // 3-bit index; both restart with each line.
      if (h_last) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_last) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px  <= bar_px + BAR_CW'(1);
      end

      if (at_origin) begin
        pat_q   <= pattern_e'(pattern_sel);
        solid_q <= solid_rgb;
      end

      {red, green, blue} <= active ? rgb_c : 24'h000000;
      de          <= active;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Self-checking bench for video_timing_pattern_gen, using a reduced raster
// (360x42 total, 320x36 active) so several whole frames fit in a short run.
module tb_video_timing_pattern_gen;

  localparam int   HA  = 320;
  localparam int   HFP = 8;
  localparam int   HSW = 16;
  localparam int   HBP = 16;
  localparam int   VA  = 36;
  localparam int   VFP = 2;
  localparam int   VSW = 2;
  localparam int   VBP = 2;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b0;
  localparam int   H_T   = HA + HFP + HSW + HBP;
  localparam int   V_T   = VA + VFP + VSW + VBP;
  localparam int   FRAME = H_T * V_T;

  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rstin;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [7:0]  red, green, blue;
  logic        de, hsync, vsync, frame_start;

  int compared   = 0;
  int mismatched = 0;

  // Reference-model state: n = pixels shown since reset release.
  int          n = 0;
  int          m_x = 0;
  int          m_y = 0;
  bit          m_valid = 1'b0;
  int          m_pat = 0;
  logic [23:0] m_solid = '0;
  bit          rand_solid = 1'b0;
  bit          rand_pat = 1'b0;

  always #5 clk = ~clk;

  video_timing_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HS_POL (HSP), .VS_POL (VSP), .CNT_W (12)
  ) dut (
    .clkin       (clk),
    .rstin       (rstin),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  // Expected {rgb, de, hsync, vsync, frame_start} for raster position (x,y).
  function automatic logic [27:0] model_out(input int x, input int y, input int pat,
                                            input logic [23:0] solid);
    logic [23:0] c;
    logic [7:0]  r8;
    logic        d, hs, vs, fs;
    d  = (x < HA) && (y < VA);
    hs = (x >= HA + HFP && x < HA + HFP + HSW) ? HSP : ~HSP;
    vs = (y >= VA + VFP && y < VA + VFP + VSW) ? VSP : ~VSP;
    fs = (x == 0) && (y == 0);
    r8 = 8'(x % 256);
    c  = 24'h000000;
    if (d) begin
      case (pat)
        0:       c = BAR_TAB[x / (HA / 8)];
        1:       c = solid;
        2:       c = (x % 32 == 0 || y % 32 == 0) ? 24'hFFFFFF : 24'h000000;
        default: c = {r8, r8, r8};
      endcase
    end
    return {c, d, hs, vs, fs};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare every output against the model.
  task automatic step();
    logic [27:0] exp_v;
    bit          was_rst;
    was_rst = rstin;
    @(posedge clk);
    if (was_rst) begin
      n       = 0;
      m_valid = 1'b0;
      exp_v   = {24'h000000, 1'b0, ~HSP, ~VSP, 1'b0};
    end else begin
      if (n % FRAME == 0) begin
        m_pat   = int'(pattern_sel);
        m_solid = solid_rgb;
      end
      m_x     = n % H_T;
      m_y     = (n / H_T) % V_T;
      m_valid = 1'b1;
      n++;
      exp_v   = model_out(m_x, m_y, m_pat, m_solid);
    end
    #1;
    check(was_rst ? "reset" : $sformatf("pixel(%0d,%0d)", m_x, m_y),
          {4'h0, red, green, blue, de, hsync, vsync, frame_start}, {4'h0, exp_v});
  endtask

  // Step until pixel (tx,ty) is on the outputs, within one frame.
  task automatic run_to(input int tx, input int ty);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < FRAME + 2; k++) begin
      if (rand_solid) solid_rgb = $urandom;
      if (rand_pat)   pattern_sel = 2'($urandom_range(3, 0));
      step();
      if (m_valid && m_x == tx && m_y == ty) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      compared++;
      mismatched++;
      $error("FAIL run_to(%0d,%0d): position not reached, last (%0d,%0d)", tx, ty, m_x, m_y);
    end
  endtask

  initial begin
    rstin       = 1'b1;
    pattern_sel = 2'd2;
    solid_rgb   = 24'h123456;
    repeat (3) step();
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 0);

    // Frame 0: colour bars, solid_rgb churning (must be ignored).
    pattern_sel = 2'd0;
    rstin       = 1'b0;
    rand_solid  = 1'b1;
    step();
    check("first_fs", frame_start, 1);
    check("first_de", de, 1);
    check("first_rgb", {red, green, blue}, 24'hFFFFFF);
    run_to(39, 0);  check("bar_39", {red, green, blue}, 24'hFFFFFF);
    run_to(40, 0);  check("bar_40", {red, green, blue}, 24'hFFFF00);
    run_to(280, 0); check("bar_280", {red, green, blue}, 24'h000000);
    run_to(319, 0); check("de_319", de, 1);
    run_to(320, 0); check("de_320", de, 0);
    check("blank_320", {red, green, blue}, 24'h000000);
    run_to(327, 0); check("hs_327", hsync, 1);
    run_to(328, 0); check("hs_328", hsync, 0);
    run_to(343, 0); check("hs_343", hsync, 0);
    run_to(344, 0); check("hs_344", hsync, 1);
    run_to(0, 1);   check("line1_de", de, 1);
    check("line1_fs", frame_start, 0);

    // Ramp requested mid-frame: bars must continue to the end of this frame.
    run_to(0, 10);
    pattern_sel = 2'd3;
    run_to(40, 20);  check("bars_hold", {red, green, blue}, 24'hFFFF00);
    run_to(359, 37); check("vs_37", vsync, 1);
    run_to(0, 38);   check("vs_38", vsync, 0);
    run_to(359, 39); check("vs_39", vsync, 0);
    run_to(0, 40);   check("vs_40", vsync, 1);

    // Frame 1: ramp.
    run_to(0, 0);   check("f1_fs", frame_start, 1);
    run_to(5, 0);   check("ramp_5", {red, green, blue}, 24'h050505);
    run_to(300, 0); check("ramp_300", {red, green, blue}, 24'h2C2C2C);
    run_to(0, 5);
    pattern_sel = 2'd2;

    // Frame 2: grid.
    run_to(5, 0);  check("grid_5_0", {red, green, blue}, 24'hFFFFFF);
    run_to(32, 1); check("grid_32_1", {red, green, blue}, 24'hFFFFFF);
    run_to(33, 1); check("grid_33_1", {red, green, blue}, 24'h000000);
    run_to(5, 32); check("grid_5_32", {red, green, blue}, 24'hFFFFFF);
    run_to(5, 33); check("grid_5_33", {red, green, blue}, 24'h000000);
    pattern_sel = 2'd1;

    // Frame 3: solid colour latched at frame start while solid_rgb keeps changing.
    run_to(0, 0);    check("solid_0", {red, green, blue}, m_solid);
    run_to(100, 10); check("solid_hold", {red, green, blue}, m_solid);

    // Frame 4: random selections, then reset mid-frame.
    rand_pat = 1'b1;
    run_to(0, 0);
    run_to(300, 20);
    rand_pat   = 1'b0;
    rand_solid = 1'b0;
    rstin = 1'b1;
    step();
    check("mid_rst_de", de, 0);
    check("mid_rst_hs", hsync, 1);
    check("mid_rst_vs", vsync, 1);
    check("mid_rst_rgb", {red, green, blue}, 24'h000000);
    check("mid_rst_fs", frame_start, 0);
    rstin       = 1'b0;
    pattern_sel = 2'd0;
    step();
    check("rel_fs", frame_start, 1);
    check("rel_de", de, 1);
    check("rel_rgb", {red, green, blue}, 24'hFFFFFF);
    rand_solid = 1'b1;
    run_to(100, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
Generates raster timing (de, hsync, vsync) and a selectable test-pattern pixel stream in the pixel clock domain. Its outputs drive the three per-channel TMDS encoders directly:
- red, green, blue feed each encoder's din.
- de feeds all three encoders.
- hsync and vsync feed c0 and c1 of the blue-channel encoder.

All outputs are registered and mutually aligned, so no external re-alignment is needed.

Parameters:
H_ACTIVE, 640, active pixels per line; must be a multiple of 8
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, hsync pulse width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vsync pulse width, in lines
V_BP, 33, vertical back porch, in lines
HS_POL, 0, active level of hsync
VS_POL, 0, active level of vsync
CNT_W, 12, width of the h and v counters

Ports:
clkin  input  1  pixel clock
rstin  input  1  reset; synchronous, active-high
pattern_sel  input  2  pattern: 0 = colour bars, 1 = solid, 2 = grid, 3 = horizontal ramp
solid_rgb  input  24  solid colour {R,G,B}, used when pattern_sel = 1
red  output  8  red pixel data
green  output  8  green pixel data
blue  output  8  blue pixel data
de  output  1  data enable; high during the active region
hsync  output  1  horizontal sync, polarity set by HS_POL
vsync  output  1  vertical sync, polarity set by VS_POL
frame_start  output  1  one-cycle pulse coincident with pixel (0,0)

Behaviour:
- Clock and reset: one clock, clkin. rstin is synchronous and active-high; it is sampled only on the clkin rising edge.
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments only when h_cnt wraps. It runs 0..V_TOTAL-1 and wraps to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync is active when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync is active when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- vsync is evaluated per line, so it changes only at h_cnt = 0.
- Latency: all outputs are registered exactly 1 cycle after the counter state they describe.
- Reset values, on any clkin edge with rstin = 1:
  - red, green, blue = 0; de = 0; frame_start = 0.
  - hsync = ~HS_POL; vsync = ~VS_POL.
  - h_cnt = 0, v_cnt = 0.
  - Latched pattern_sel = 0; latched solid_rgb = 0.
- First edge after reset release:
  - Outputs show pixel (0,0) with de = 1 and frame_start = 1.
  - Counters advance to (1,0).
- Reset asserted mid-frame: on the next edge, outputs go to their reset values and counters clear. There is no partial-frame completion.
- Parameter latch: pattern_sel and solid_rgb are sampled only when the counters are at (0,0). Changes during a frame take effect at the next frame start.
- Blanking: red, green and blue are forced to 0 whenever de = 0, regardless of pattern.
- Pattern 0, colour bars:
  - 8 bars, each H_ACTIVE/8 pixels wide, in this order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - The bar index comes from a bar-width sub-counter plus a 3-bit bar counter. Both clear at h_cnt = 0. No divider is used.
- Pattern 1, solid: output is the latched solid_rgb.
- Pattern 2, grid: FFFFFF where h_cnt[4:0] = 0 or v_cnt[4:0] = 0; 000000 elsewhere.
- Pattern 3, horizontal ramp: red = green = blue = h_cnt[7:0], wrapping every 256 pixels.
- Counters never exceed their TOTAL-1; wrap arithmetic is modulo TOTAL, not modulo 2^CNT_W.

Decomposition:
- Shared package vtg_pkg holds:
  - the 640x480@60 timing constants;
  - the pattern_sel encodings (PAT_BARS, PAT_SOLID, PAT_GRID, PAT_RAMP);
  - the 8 bar colour constants.
- One sub-module, vtg_pattern_rgb: combinational colour selection from h_cnt, v_cnt, bar index, latched pattern_sel and latched solid_rgb.
- Counters, sync decode and the output registers stay in the top module.

Test Plan:
- Line timing: release reset, default params -> de = 1 for output cycles 0..639; hsync = 0 for cycles 656..751; period exactly 800 cycles.
- Frame timing: run 2 frames -> vsync = 0 exactly during lines 490-491; frame_start pulses at cycle 0 and cycle 420000 only.
- Colour bars: pattern_sel = 0 -> pixel 0 = FFFFFF; pixel 79 = FFFFFF; pixel 80 = FFFF00; pixel 560 = 000000; pixel 640 = 000000 with de = 0.
- Mid-frame select change: set pattern_sel = 3 at line 100 of a bars frame -> bars continue to end of frame; next frame pixel 5 = 050505 and pixel 300 = 2C2C2C.
- Grid: pattern_sel = 2 -> (x=32,y=1) = FFFFFF; (33,1) = 000000; (5,0) = FFFFFF; (5,64) = FFFFFF.
- Mid-frame reset: assert rstin at (300,200) -> next edge de = 0, hsync = 1, vsync = 1, rgb = 0; on release, frame_start = 1 with pixel (0,0) on the first edge.
